booth_mac_seq: RTL and testbench

Sequencing multiply-accumulate controller that wraps the 8x8 sequential Booth multiplier. It accepts signed operand pairs over a valid/ready stream and drives the multiplier's start/operand inputs. It waits for the multiplier's busy flag to drop, then sign-extends and accumulates each 16-bit product. When a pair tagged last has been accumulated, it presents the sum on a valid/ready output stream.

---
 rtl/booth_mac_seq.sv | 155 +++++++++++++++
 tb/tb_booth_mac_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_seq.sv
// booth_mac_seq: multiply-accumulate sequencer around an 8x8 sequential Booth
// multiplier. Operand pairs arrive on a valid/ready stream. Each pair starts one
// multiplication, and its product is sign-extended and added into a wrapping
// accumulator. The sum is presented on the output stream once the pair tagged
// last has been accumulated.
// ACC_W is intended to lie in the range 16..32.
module booth_mac_seq #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_mc,
  input  logic [7:0]       in_mp,
  input  logic             in_last,
  output logic             mul_start,
  output logic [7:0]       mul_mc,
  output logic [7:0]       mul_mp,
  input  logic [15:0]      mul_prd,
  input  logic             mul_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [7:0]       out_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]       mc_q;
  logic [7:0]       mp_q;
  logic             last_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [7:0]       cnt_q;

  logic             accept;
  logic             capture;
  logic             clear;
  logic [ACC_W-1:0] prd_ext;
  logic [ACC_W-1:0] sum;
  logic             ovf_now;
  logic [7:0]       cnt_inc;

  // Sign-extend the 16-bit product to the accumulator width. The 16-bit case
  // needs no extension, and a zero-width replication is not legal.
  generate
    if (ACC_W > 16) begin : g_sext
      assign prd_ext = {{(ACC_W-16){mul_prd[15]}}, mul_prd};
    end else begin : g_nosext
      assign prd_ext = mul_prd[ACC_W-1:0];
    end
  endgenerate

  // Wrapping sum. Overflow occurs when both addends share a sign and the result's sign differs.
  assign sum     = acc_q + prd_ext;
  assign ovf_now = (acc_q[ACC_W-1] == prd_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // State register; reset discards any pending result and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake strobes. mul_busy is ignored in START because it is stale.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!mul_busy) begin
          capture   = 1'b1;
          state_nxt = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand registers feed the multiplier and stay stable until the next accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q   <= 8'd0;
      mp_q   <= 8'd0;
      last_q <= 1'b0;
    end else if (accept) begin
      mc_q   <= in_mc;
      mp_q   <= in_mp;
      last_q <= in_last;
    end
  end

  // Accumulator, term count and sticky overflow; the product is taken only on the first not-busy edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= 8'd0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= 8'd0;
      ovf_q <= 1'b0;
    end else if (capture) begin
      acc_q <= sum;
      cnt_q <= cnt_inc;
      ovf_q <= ovf_q | ovf_now;
    end
  end

  assign mul_mc  = mc_q;
  assign mul_mp  = mp_q;
  assign out_acc = acc_q;
  assign out_ovf = ovf_q;
  assign out_cnt = cnt_q;

endmodule

// File: tb/tb_booth_mac_seq.sv
// tb_booth_mac_seq: directed test of the MAC sequencer. A 24-bit and a 16-bit
// instance share one behavioural sequential multiplier. sel16 chooses which
// instance the stimulus and observations address.
module tb_booth_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [7:0] in_mc;
  logic [7:0] in_mp;
  logic in_last;
  logic out_ready;
  logic sel16;

  logic in_ready24, in_ready16;
  logic start24, start16;
  logic [7:0] mc24, mp24, mc16, mp16;
  logic out_valid24, out_valid16;
  logic [23:0] acc24;
  logic [15:0] acc16;
  logic ovf24, ovf16;
  logic [7:0] cnt24, cnt16;

  // multiplier model state
  logic [15:0] m_prd = 16'h5A5A;
  logic m_busy = 1'b0;
  logic m_scr = 1'b0;
  logic [3:0] m_cnt = 4'd0;
  logic signed [15:0] m_a = 16'sd0;
  logic signed [15:0] m_b = 16'sd0;

  logic m_start;
  logic [7:0] m_mc, m_mp;

  logic obs_in_ready, obs_start, obs_out_valid, obs_ovf;
  logic [7:0] obs_mc, obs_mp, obs_cnt;
  logic [31:0] obs_acc;

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] res_acc[$];
  logic [7:0] res_cnt[$];

  always #5 clk = ~clk;

  booth_mac_seq #(.ACC_W(24)) dut24 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel16), .in_ready(in_ready24),
    .in_mc(in_mc), .in_mp(in_mp), .in_last(in_last),
    .mul_start(start24), .mul_mc(mc24), .mul_mp(mp24),
    .mul_prd(m_prd), .mul_busy(m_busy),
    .out_valid(out_valid24), .out_ready(out_ready),
    .out_acc(acc24), .out_ovf(ovf24), .out_cnt(cnt24)
  );

  booth_mac_seq #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel16), .in_ready(in_ready16),
    .in_mc(in_mc), .in_mp(in_mp), .in_last(in_last),
    .mul_start(start16), .mul_mc(mc16), .mul_mp(mp16),
    .mul_prd(m_prd), .mul_busy(m_busy),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(acc16), .out_ovf(ovf16), .out_cnt(cnt16)
  );

  assign m_start = start24 | start16;
  assign m_mc    = start16 ? mc16 : mc24;
  assign m_mp    = start16 ? mp16 : mp24;

  assign obs_in_ready  = sel16 ? in_ready16 : in_ready24;
  assign obs_start     = sel16 ? start16 : start24;
  assign obs_mc        = sel16 ? mc16 : mc24;
  assign obs_mp        = sel16 ? mp16 : mp24;
  assign obs_out_valid = sel16 ? out_valid16 : out_valid24;
  assign obs_ovf       = sel16 ? ovf16 : ovf24;
  assign obs_cnt       = sel16 ? cnt16 : cnt24;
  assign obs_acc       = sel16 ? {{16{acc16[15]}}, acc16} : {{8{acc24[23]}}, acc24};

  // Sequential multiplier: loads on start, busy for 8 iterations, then keeps changing the product.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'd8;
      m_a    <= 16'(signed'(m_mc));
      m_b    <= 16'(signed'(m_mp));
      m_prd  <= 16'h5A5A;
      m_scr  <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 4'd1) begin
        m_busy <= 1'b0;
        m_prd  <= 16'(m_a * m_b);
        m_scr  <= 1'b1;
      end
      m_cnt <= m_cnt - 4'd1;
    end else if (m_scr) begin
      m_prd <= m_prd ^ 16'h3C3C;
    end
  end

  // Record every completed output handshake.
  always @(posedge clk) begin
    if (rst_n && obs_out_valid && out_ready) begin
      res_acc.push_back(obs_acc);
      res_cnt.push_back(obs_cnt);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] mc, input logic [7:0] mp, input logic last,
                               input logic hold, output int acc_cyc);
    logic ok;
    logic rdy;
    ok = 1'b0;
    acc_cyc = 0;
    in_mc = mc;
    in_mp = mp;
    in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rdy = obs_in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!hold) in_valid = 1'b0;
    checkOutput("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic waitOut(input int budget, output int edges);
    logic got;
    got = 1'b0;
    edges = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (obs_out_valid) begin
        got = 1'b1;
        edges = i;
        break;
      end
    end
    checkOutput("out_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int t1, t2, t3, lat;
    logic stable_v, stable_a, stable_c, stable_r;
    logic drained;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_mc = 8'd0;
    in_mp = 8'd0;
    in_last = 1'b0;
    out_ready = 1'b0;
    sel16 = 1'b0;

    // reset values
    repeat (2) tick();
    checkOutput("rst_in_ready", {31'd0, obs_in_ready}, 32'd1);
    checkOutput("rst_mul_start", {31'd0, obs_start}, 32'd0);
    checkOutput("rst_mul_mc", {24'd0, obs_mc}, 32'd0);
    checkOutput("rst_mul_mp", {24'd0, obs_mp}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, obs_out_valid}, 32'd0);
    checkOutput("rst_out_acc", obs_acc, 32'd0);
    checkOutput("rst_out_ovf", {31'd0, obs_ovf}, 32'd0);
    checkOutput("rst_out_cnt", {24'd0, obs_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single pair 3*5
    $display("[TB] single pair");
    out_ready = 1'b1;
    applyStimulus(8'd3, 8'd5, 1'b1, 1'b0, t1);
    checkOutput("t1_mul_start", {31'd0, obs_start}, 32'd1);
    checkOutput("t1_mul_mc", {24'd0, obs_mc}, 32'd3);
    checkOutput("t1_mul_mp", {24'd0, obs_mp}, 32'd5);
    waitOut(40, lat);
    checkOutput("t1_latency", lat, 32'd10);
    checkOutput("t1_acc", obs_acc, 32'd15);
    checkOutput("t1_cnt", {24'd0, obs_cnt}, 32'd1);
    checkOutput("t1_ovf", {31'd0, obs_ovf}, 32'd0);
    tick();
    checkOutput("t1_valid_drop", {31'd0, obs_out_valid}, 32'd0);
    checkOutput("t1_in_ready", {31'd0, obs_in_ready}, 32'd1);

    // signed pairs with backpressure
    $display("[TB] signed pairs and backpressure");
    out_ready = 1'b0;
    applyStimulus(8'hF9, 8'd9, 1'b0, 1'b0, t1);
    tick();
    checkOutput("t2_start_pulse", {31'd0, obs_start}, 32'd0);
    checkOutput("t2_mc_hold", {24'd0, obs_mc}, 32'hF9);
    applyStimulus(8'd127, 8'h81, 1'b0, 1'b0, t2);
    checkOutput("t2_spacing_a", t2 - t1, 32'd11);
    applyStimulus(8'h81, 8'h81, 1'b1, 1'b0, t3);
    checkOutput("t2_spacing_b", t3 - t2, 32'd11);
    waitOut(40, lat);
    checkOutput("t2_latency", lat, 32'd10);
    checkOutput("t2_acc", obs_acc, 32'hFFFF_FFC1);
    checkOutput("t2_cnt", {24'd0, obs_cnt}, 32'd3);
    checkOutput("t2_ovf", {31'd0, obs_ovf}, 32'd0);
    in_mc = 8'd5;
    in_mp = 8'd6;
    in_last = 1'b1;
    in_valid = 1'b1;
    stable_v = 1'b1;
    stable_a = 1'b1;
    stable_c = 1'b1;
    stable_r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_out_valid !== 1'b1) stable_v = 1'b0;
      if (obs_acc !== 32'hFFFF_FFC1) stable_a = 1'b0;
      if (obs_cnt !== 8'd3) stable_c = 1'b0;
      if (obs_in_ready !== 1'b0) stable_r = 1'b0;
    end
    checkOutput("bp_valid_held", {31'd0, stable_v}, 32'd1);
    checkOutput("bp_acc_held", {31'd0, stable_a}, 32'd1);
    checkOutput("bp_cnt_held", {31'd0, stable_c}, 32'd1);
    checkOutput("bp_in_ready_low", {31'd0, stable_r}, 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", {31'd0, obs_out_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, obs_in_ready}, 32'd1);
    checkOutput("bp_release_acc", obs_acc, 32'd0);
    checkOutput("bp_release_cnt", {24'd0, obs_cnt}, 32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_held_pair_start", {31'd0, obs_start}, 32'd1);
    waitOut(40, lat);
    checkOutput("bp_held_pair_acc", obs_acc, 32'd30);
    checkOutput("bp_held_pair_cnt", {24'd0, obs_cnt}, 32'd1);
    tick();

    // 16-bit accumulator wraps
    $display("[TB] ACC_W=16 wrap");
    sel16 = 1'b1;
    tick();
    applyStimulus(8'd127, 8'd127, 1'b0, 1'b0, t1);
    applyStimulus(8'd127, 8'd127, 1'b0, 1'b0, t1);
    applyStimulus(8'd127, 8'd127, 1'b1, 1'b0, t1);
    waitOut(40, lat);
    checkOutput("w16_acc", obs_acc, 32'hFFFF_BD03);
    checkOutput("w16_ovf", {31'd0, obs_ovf}, 32'd1);
    checkOutput("w16_cnt", {24'd0, obs_cnt}, 32'd3);
    tick();
    sel16 = 1'b0;
    tick();

    // reset during WAIT
    $display("[TB] reset mid-wait");
    applyStimulus(8'd10, 8'd10, 1'b1, 1'b0, t1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mr_in_ready", {31'd0, obs_in_ready}, 32'd1);
    checkOutput("mr_mul_start", {31'd0, obs_start}, 32'd0);
    checkOutput("mr_mul_mc", {24'd0, obs_mc}, 32'd0);
    checkOutput("mr_mul_mp", {24'd0, obs_mp}, 32'd0);
    checkOutput("mr_out_valid", {31'd0, obs_out_valid}, 32'd0);
    checkOutput("mr_acc", obs_acc, 32'd0);
    checkOutput("mr_cnt", {24'd0, obs_cnt}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(8'd2, 8'd2, 1'b1, 1'b0, t1);
    waitOut(40, lat);
    checkOutput("mr_after_acc", obs_acc, 32'd4);
    checkOutput("mr_after_cnt", {24'd0, obs_cnt}, 32'd1);
    tick();

    // continuous valid, last on every second pair
    $display("[TB] continuous stream");
    res_acc.delete();
    res_cnt.delete();
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b1, t1);
    applyStimulus(8'd2, 8'd2, 1'b1, 1'b1, t1);
    applyStimulus(8'd3, 8'd3, 1'b0, 1'b1, t1);
    applyStimulus(8'd4, 8'd4, 1'b1, 1'b0, t1);
    drained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_acc.size() >= 2) begin
        drained = 1'b1;
        break;
      end
    end
    checkOutput("cs_drain_timeout", {31'd0, drained}, 32'd1);
    repeat (15) tick();
    checkOutput("cs_result_count", res_acc.size(), 32'd2);
    if (res_acc.size() >= 2) begin
      checkOutput("cs_result0_acc", res_acc[0], 32'd5);
      checkOutput("cs_result0_cnt", {24'd0, res_cnt[0]}, 32'd2);
      checkOutput("cs_result1_acc", res_acc[1], 32'd25);
      checkOutput("cs_result1_cnt", {24'd0, res_cnt[1]}, 32'd2);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
